// File: rtl/cpu_core_if.sv
// cpu_core_if: memory-side address and strobe bundle of cpu_core.
// The 16-bit data bus is a bidirectional net and is a separate inout port on
// the core, so it can be resolved together with the SRAM's tristate driver.
interface cpu_core_if;
  logic [15:0] address;
  logic        memNotRead;
  logic        memNotWrite;

  modport master (output address, output memNotRead, output memNotWrite);
  modport slave  (input  address, input  memNotRead, input  memNotWrite);
endinterface

// File: rtl/cpu_core.sv
// cpu_core: 16-bit multi-cycle core with r0-r6, PC as register 7, C/Z flags,
// and a shared word-addressed SRAM bus with active-low strobes.
// Optional macro CPU_UNDEF_TRAP_EN: undefined opcodes trap into ERROR
// (error = 01, halted = 1); without it they behave as 2-cycle NOPs.
module cpu_core (
  input  logic        clock,
  input  logic        reset,
  cpu_core_if.master  bus,
  inout  wire  [15:0] data,
  output logic        halted,
  output logic [1:0]  error
);

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_MEMHOLD, S_HALTED, S_ERROR
  } state_t;

  localparam logic [6:0] OP_NOP  = 7'h00, OP_ADD = 7'h01, OP_SUB = 7'h02,
                         OP_AND  = 7'h03, OP_OR  = 7'h04, OP_XOR = 7'h05,
                         OP_MOV  = 7'h06, OP_LDI = 7'h07, OP_LD  = 7'h08,
                         OP_ST   = 7'h09, OP_JMP = 7'h0A, OP_JZ  = 7'h0B,
                         OP_JC   = 7'h0C, OP_JNZ = 7'h0D, OP_SHL = 7'h0E,
                         OP_HALT = 7'h7F;

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] pc_q, pc_d;
  logic [15:0] r_q [7];
  logic        c_q, c_d, z_q, z_d;

  logic [6:0]  opcode;
  logic [2:0]  op0, op1, op2;
  logic [15:0] op1_val, op2_val;
  logic [16:0] sum;
  logic [15:0] res;
  logic        wr_en;

  logic [15:0] address_d;
  logic        rd_n, wr_n, data_oe;

  assign opcode = ir_q[15:9];
  assign op0    = ir_q[8:6];
  assign op1    = ir_q[5:3];
  assign op2    = ir_q[2:0];

  // Index 7 reads as the PC, which already points past the instruction word.
  assign op1_val = (op1 == 3'd7) ? pc_q : r_q[op1];
  assign op2_val = (op2 == 3'd7) ? pc_q : r_q[op2];
  assign sum     = {1'b0, op1_val} + {1'b0, op2_val};

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        if (opcode == OP_ST)        state_d = S_MEMHOLD;
        else if (opcode == OP_HALT) state_d = S_HALTED;
`ifdef CPU_UNDEF_TRAP_EN
        else if (opcode > OP_SHL)   state_d = S_ERROR;
`endif
      end
      S_MEMHOLD: state_d = S_FETCH;
      default:   state_d = state_q;
    endcase
  end

  // Bus strobes, address, data enable and status outputs
  always_comb begin
    address_d = pc_q;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    data_oe   = 1'b0;
    case (state_q)
      S_FETCH: rd_n = 1'b0;
      S_EXEC: begin
        case (opcode)
          OP_LDI: rd_n = 1'b0;
          OP_LD:  begin address_d = op1_val; rd_n = 1'b0; end
          OP_ST:  begin address_d = op1_val; wr_n = 1'b0; data_oe = 1'b1; end
          default: ;
        endcase
      end
      S_MEMHOLD: begin address_d = op1_val; data_oe = 1'b1; end
      default: ;
    endcase
    halted = (state_q == S_HALTED) || (state_q == S_ERROR);
`ifdef CPU_UNDEF_TRAP_EN
    error  = (state_q == S_ERROR) ? 2'b01 : 2'b00;
`else
    error  = '0;
`endif
  end

  // Reset forces the read strobe high even though FETCH is the reset state.
  assign bus.address     = address_d;
  assign bus.memNotRead  = rd_n | reset;
  assign bus.memNotWrite = wr_n;
  assign data            = data_oe ? op2_val : 'z;

  // Execute: result, flag and PC computation
  always_comb begin
    pc_d  = pc_q;
    c_d   = c_q;
    z_d   = z_q;
    res   = '0;
    wr_en = 1'b0;
    if (state_q == S_FETCH) begin
      pc_d = pc_q + 16'd1;
    end else if (state_q == S_EXEC) begin
      case (opcode)
        OP_ADD: begin res = sum[15:0];          c_d = sum[16];            wr_en = 1'b1; end
        OP_SUB: begin res = op1_val - op2_val;  c_d = (op1_val >= op2_val); wr_en = 1'b1; end
        OP_AND: begin res = op1_val & op2_val;  c_d = 1'b0;               wr_en = 1'b1; end
        OP_OR:  begin res = op1_val | op2_val;  c_d = 1'b0;               wr_en = 1'b1; end
        OP_XOR: begin res = op1_val ^ op2_val;  c_d = 1'b0;               wr_en = 1'b1; end
        OP_SHL: begin res = {op1_val[14:0], 1'b0}; c_d = op1_val[15];     wr_en = 1'b1; end
        OP_MOV: begin res = op1_val; wr_en = 1'b1; end
        OP_LDI: begin res = data; wr_en = 1'b1; pc_d = pc_q + 16'd1; end
        OP_LD:  begin res = data; wr_en = 1'b1; end
        OP_JMP: pc_d = op1_val;
        OP_JZ:  if (z_q)  pc_d = op1_val;
        OP_JC:  if (c_q)  pc_d = op1_val;
        OP_JNZ: if (!z_q) pc_d = op1_val;
        default: ;
      endcase
      case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: z_d = (res == '0);
        default: ;
      endcase
      // A register write to index 7 overrides any PC increment: it is a jump.
      if (wr_en && op0 == 3'd7) pc_d = res;
    end
  end

  // Architectural state update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      ir_q <= '0;
      c_q  <= 1'b0;
      z_q  <= 1'b0;
      for (int unsigned i = 0; i < 7; i++) r_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      c_q  <= c_d;
      z_q  <= z_d;
      if (state_q == S_FETCH) ir_q <= data;
      if (wr_en && op0 != 3'd7) r_q[op0] <= res;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed programs with hand-computed results for cpu_core.
module tb_cpu_core;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        halted;
  logic [1:0]  error;
  wire  [15:0] data;

  cpu_core_if bus ();

  cpu_core dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .data   (data),
    .halted (halted),
    .error  (error)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM model: 512 words visible, address[15] is active-low CS.
  logic [15:0] mem [0:511];
  assign data = (!bus.memNotRead && !bus.address[15]) ? mem[bus.address[8:0]] : 'z;
  always @(posedge clock)
    if (!bus.memNotWrite && !bus.address[15]) mem[bus.address[8:0]] = data;

  int errors = 0;
  int checks = 0;
  int wr_low, drv, both_low;

  task check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int a, input int b, input int c);
    enc = 16'((op << 9) | (a << 6) | (b << 3) | c);
  endfunction

  task begin_prog();
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
  endtask

  task go();
    wr_low = 0; drv = 0; both_low = 0;
    reset = 1'b0;
  endtask

  // One rising edge, then sample at the following falling edge.
  task tick();
    @(posedge clock);
    @(negedge clock);
    if (!bus.memNotWrite) wr_low++;
    if (dut.data_oe) drv++;
    if (!bus.memNotRead && !bus.memNotWrite) both_low++;
  endtask

  task jump_case(input string tag, input int jop, input logic [15:0] r1v, input logic [15:0] exp);
    begin_prog();
    mem[0] = enc(7, 5, 0, 0);  mem[1] = 16'h0010;
    mem[2] = enc(7, 1, 0, 0);  mem[3] = r1v;
    mem[4] = enc(4, 0, 1, 1);
    mem[5] = enc(jop, 0, 5, 0);
    mem[6] = enc(7, 6, 0, 0);  mem[7] = 16'h0BAD;  mem[8] = 16'hFE00;
    mem[16] = enc(7, 6, 0, 0); mem[17] = 16'h600D; mem[18] = 16'hFE00;
    go();
    repeat (14) tick();
    check_eq({tag, "_r6"}, dut.r_q[6], exp);
    check_eq({tag, "_halted"}, 16'(halted), 16'd1);
  endtask

  initial begin
    // Reset values while reset is held
    begin_prog();
    @(negedge clock);
    check_eq("rst_address", bus.address, 16'h0000);
    check_eq("rst_nrd", 16'(bus.memNotRead), 16'd1);
    check_eq("rst_nwr", 16'(bus.memNotWrite), 16'd1);
    check_eq("rst_halted", 16'(halted), 16'd0);
    check_eq("rst_error", 16'(error), 16'd0);
    check_eq("rst_data_oe", 16'(dut.data_oe), 16'd0);

    // LDI/LDI/ADD/HALT: halted after exactly 8 cycles
    mem[0] = enc(7, 1, 0, 0); mem[1] = 16'h1234;
    mem[2] = enc(7, 2, 0, 0); mem[3] = 16'h0001;
    mem[4] = enc(1, 0, 1, 2); mem[5] = 16'hFE00;
    go();
    repeat (7) tick();
    check_eq("add_halt_at7", 16'(halted), 16'd0);
    tick();
    check_eq("add_halt_at8", 16'(halted), 16'd1);
    check_eq("add_r0", dut.r_q[0], 16'h1235);
    check_eq("add_c", 16'(dut.c_q), 16'd0);
    check_eq("add_z", 16'(dut.z_q), 16'd0);

    // Carry/zero from ADD wrap, then SUB borrow
    begin_prog();
    mem[0] = enc(7, 1, 0, 0); mem[1] = 16'hFFFF;
    mem[2] = enc(7, 2, 0, 0); mem[3] = 16'h0001;
    mem[4] = enc(1, 0, 1, 2); mem[5] = enc(2, 3, 2, 1); mem[6] = 16'hFE00;
    go();
    repeat (6) tick();
    check_eq("wrap_r0", dut.r_q[0], 16'h0000);
    check_eq("wrap_c", 16'(dut.c_q), 16'd1);
    check_eq("wrap_z", 16'(dut.z_q), 16'd1);
    repeat (4) tick();
    check_eq("sub_r3", dut.r_q[3], 16'h0002);
    check_eq("sub_c", 16'(dut.c_q), 16'd0);
    check_eq("sub_z", 16'(dut.z_q), 16'd0);
    check_eq("sub_halted", 16'(halted), 16'd1);

    // ST then LD: write strobe low one cycle, data driven only in ST EXEC/MEMHOLD
    begin_prog();
    mem[0] = enc(7, 1, 0, 0); mem[1] = 16'h0100;
    mem[2] = enc(7, 2, 0, 0); mem[3] = 16'hBEEF;
    mem[4] = enc(9, 0, 1, 2); mem[5] = enc(8, 4, 1, 0); mem[6] = 16'hFE00;
    go();
    for (int i = 0; i < 11; i++) begin
      tick();
      if (!bus.memNotWrite) begin
        check_eq("st_address", bus.address, 16'h0100);
        check_eq("st_data", data, 16'hBEEF);
      end
      if (i == 9) check_eq("st_halt_at10", 16'(halted), 16'd0);
    end
    check_eq("st_halt_at11", 16'(halted), 16'd1);
    check_eq("st_wr_cycles", 16'(wr_low), 16'd1);
    check_eq("st_drive_cycles", 16'(drv), 16'd2);
    check_eq("strobes_both_low", 16'(both_low), 16'd0);
    check_eq("st_mem", mem[256], 16'hBEEF);
    check_eq("ld_r4", dut.r_q[4], 16'hBEEF);

    // Conditional jumps
    jump_case("jz_taken", 11, 16'h0000, 16'h600D);
    jump_case("jz_fall", 11, 16'h0001, 16'h0BAD);
    jump_case("jnz_fall", 13, 16'h0000, 16'h0BAD);
    jump_case("jnz_taken", 13, 16'h0001, 16'h600D);

    // Reset during the EXEC cycle of ST
    begin_prog();
    mem[0] = enc(7, 1, 0, 0); mem[1] = 16'h0100;
    mem[2] = enc(7, 2, 0, 0); mem[3] = 16'h1111;
    mem[4] = enc(9, 0, 1, 2); mem[5] = 16'hFE00;
    mem[256] = 16'hAAAA;
    go();
    repeat (5) tick();
    check_eq("abort_nwr_before", 16'(bus.memNotWrite), 16'd0);
    reset = 1'b1;
    #1;
    check_eq("abort_nwr_async", 16'(bus.memNotWrite), 16'd1);
    check_eq("abort_data_oe", 16'(dut.data_oe), 16'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("abort_fetch_addr", bus.address, 16'h0000);
    check_eq("abort_fetch_nrd", 16'(bus.memNotRead), 16'd0);
    check_eq("abort_mem", mem[256], 16'hAAAA);
    tick();
    check_eq("abort_pc", dut.pc_q, 16'h0001);
    check_eq("abort_ir", dut.ir_q, 16'h0E40);

    // Undefined opcode 0x40 followed by HALT
    begin_prog();
    mem[0] = 16'h8000; mem[1] = 16'hFE00;
    go();
    repeat (2) tick();
`ifdef CPU_UNDEF_TRAP_EN
    check_eq("undef_halted", 16'(halted), 16'd1);
    check_eq("undef_error", 16'(error), 16'd1);
    repeat (2) tick();
    check_eq("undef_stays", 16'(error), 16'd1);
    check_eq("undef_pc", dut.pc_q, 16'h0001);
`else
    check_eq("undef_halted", 16'(halted), 16'd0);
    check_eq("undef_error", 16'(error), 16'd0);
    repeat (2) tick();
    check_eq("undef_then_halt", 16'(halted), 16'd1);
    check_eq("undef_error_end", 16'(error), 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
